// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and the byte
// returned to the master when the transmit FIFO has nothing to offer.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_DATA  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } i2c_state_t;

  localparam logic [7:0] EMPTY_FILL = 8'hFF;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a stability filter: the output level only
// follows the synchronized input after FILT consecutive differing samples.
// Everything resets to 1 because an idle I2C bus sits high.
module i2c_line_filter #(
  parameter int FILT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level
);

  localparam int CW = (FILT > 1) ? $clog2(FILT + 1) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Synchronize, then count how long the new value has been stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= line;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_i2c_slave.sv
// I2C target: byte writes go out on rx_data/rx_valid, byte reads are pulled
// from a show-ahead FIFO. SCL is only observed; SDA is only ever pulled low.
//
// Handshake: rx_valid is a one-cycle strobe with no back-pressure, rx_first
// qualifies it. tx_rdreq is a one-cycle pop issued in the same cycle tx_data
// is captured, and only while tx_empty is 0.
module if_i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         FILT     = 4
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic       tx_rdreq,
  output logic       busy,
  output logic       stop_det,
  output logic [2:0] dbg_state
);

  i2c_state_t state, state_next;

  logic       scl_f, sda_f, scl_q, sda_q;
  logic       scl_rise, scl_fall, start_cond, stop_cond, bit_last;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] load_byte;
  logic       rnw;
  logic       phase;          // ACK states: SDA already pulled; RD_ACK: master ACKed
  logic       first_pending;
  logic       sda_oen_r;

  i2c_line_filter #(.FILT(FILT)) u_scl_filt (.clk(clk), .rst(rst), .line(scl), .level(scl_f));
  i2c_line_filter #(.FILT(FILT)) u_sda_filt (.clk(clk), .rst(rst), .line(sda), .level(sda_f));

  assign sda       = sda_oen_r ? 1'b0 : 1'bz;
  assign dbg_state = state;

  assign scl_rise   = scl_f & ~scl_q;
  assign scl_fall   = ~scl_f & scl_q;
  assign start_cond = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_cond  = scl_f & scl_q & ~sda_q & sda_f;
  assign bit_last   = (bit_cnt == 3'd7);
  assign load_byte  = tx_empty ? EMPTY_FILL : tx_data;

  // Previous filtered levels for edge and START/STOP detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and busy decode; bus conditions override any bit event.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      ST_ADDR_ACK, ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK: busy = 1'b1;
      default: busy = 1'b0;
    endcase
    if (stop_cond) begin
      state_next = ST_IDLE;
    end else if (start_cond) begin
      state_next = ST_ADDR;
    end else begin
      case (state)
        ST_ADDR:
          if (scl_rise && bit_last)
            state_next = (shift[6:0] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK:
          if (scl_fall && phase) state_next = rnw ? ST_RD_DATA : ST_WR_DATA;
        ST_WR_DATA:
          if (scl_rise && bit_last) state_next = ST_WR_ACK;
        ST_WR_ACK:
          if (scl_fall && phase) state_next = ST_WR_DATA;
        ST_RD_DATA:
          if (scl_rise && bit_last) state_next = ST_RD_ACK;
        ST_RD_ACK:
          if (scl_rise && sda_f)       state_next = ST_IGNORE;
          else if (scl_fall && phase)  state_next = ST_RD_DATA;
        default: state_next = state;
      endcase
    end
  end

  // Shifter, bit counter, SDA pull-down and the strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt       <= '0;
      shift         <= '0;
      rnw           <= 1'b0;
      phase         <= 1'b0;
      first_pending <= 1'b0;
      sda_oen_r     <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_first      <= 1'b0;
      tx_rdreq      <= 1'b0;
      stop_det      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_rdreq <= 1'b0;
      stop_det <= 1'b0;
      if (stop_cond) begin
        sda_oen_r <= 1'b0;
        stop_det  <= 1'b1;
        bit_cnt   <= '0;
        phase     <= 1'b0;
      end else if (start_cond) begin
        sda_oen_r <= 1'b0;
        bit_cnt   <= '0;
        phase     <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_WR_DATA: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_f};
              bit_cnt <= bit_cnt + 3'd1;
              phase   <= 1'b0;
              if (bit_last && state == ST_ADDR) rnw <= sda_f;
              if (bit_last && state == ST_WR_DATA) begin
                rx_data       <= {shift[6:0], sda_f};
                rx_valid      <= 1'b1;
                rx_first      <= first_pending;
                first_pending <= 1'b0;
              end
            end
          end
          ST_ADDR_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oen_r <= 1'b1;
                phase     <= 1'b1;
              end else begin
                phase <= 1'b0;
                if (state == ST_ADDR_ACK) first_pending <= 1'b1;
                if (state == ST_ADDR_ACK && rnw) begin
                  shift     <= load_byte;
                  sda_oen_r <= ~load_byte[7];
                  tx_rdreq  <= ~tx_empty;
                end else begin
                  sda_oen_r <= 1'b0;
                end
              end
            end
          end
          ST_RD_DATA: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              phase   <= 1'b0;
            end else if (scl_fall) begin
              sda_oen_r <= ~shift[7];
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              phase <= ~sda_f;
            end else if (scl_fall) begin
              if (phase) begin
                phase     <= 1'b0;
                shift     <= load_byte;
                sda_oen_r <= ~load_byte[7];
                tx_rdreq  <= ~tx_empty;
              end else begin
                sda_oen_r <= 1'b0;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_i2c_slave.sv
// Bench for if_i2c_slave: a bit-banged I2C master, a show-ahead FIFO model,
// and a transaction-level reference of what the target must return.
module tb_if_i2c_slave;
  import i2c_pkg::*;

  localparam time CLK_P = 10;
  localparam time Q     = 200;   // quarter SCL period

  // Clock/reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #(CLK_P / 2) clk = ~clk;

  // Open-drain bus with pull-ups.
  logic m_scl_low = 1'b0;
  logic m_sda_low = 1'b0;
  wire  scl_w, sda_w;
  assign scl_w = m_scl_low ? 1'b0 : 1'bz;
  assign sda_w = m_sda_low ? 1'b0 : 1'bz;
  pullup (scl_w);
  pullup (sda_w);

  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_first, tx_empty, tx_rdreq, busy, stop_det;
  logic [2:0] dbg_state;

  if_i2c_slave #(.DEV_ADDR(7'h50), .FILT(4)) dut (
    .clk(clk), .rst(rst), .scl(scl_w), .sda(sda_w),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .tx_data(tx_data), .tx_empty(tx_empty), .tx_rdreq(tx_rdreq),
    .busy(busy), .stop_det(stop_det), .dbg_state(dbg_state)
  );

  // Scoreboard state.
  int compared   = 0;
  int mismatched = 0;
  logic [8:0] exp_q[$];   // {first, data}
  logic [8:0] rx_got[$];
  logic [7:0] fifo_q[$];
  int rdreq_cnt = 0, stop_cnt = 0, busy_cnt = 0, dut_low_cnt = 0;

  // Monitors and FIFO model, all sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid) rx_got.push_back({rx_first, rx_data});
    if (stop_det) stop_cnt++;
    if (busy) busy_cnt++;
    if (sda_w === 1'b0 && !m_sda_low) dut_low_cnt++;
    if (tx_rdreq) begin
      rdreq_cnt++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    tx_empty = (fifo_q.size() == 0);
    tx_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Master driver tasks.
  task automatic m_start();
    m_sda_low = 1'b0; #Q; m_scl_low = 1'b0; #Q;
    m_sda_low = 1'b1; #Q; m_scl_low = 1'b1; #Q;
  endtask

  task automatic m_stop();
    m_sda_low = 1'b1; #Q; m_scl_low = 1'b0; #Q; m_sda_low = 1'b0; #Q;
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; #Q; m_scl_low = 1'b0; #(2 * Q); m_scl_low = 1'b1; #Q;
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; #Q; m_scl_low = 1'b0; #Q; b = sda_w; #Q; m_scl_low = 1'b1; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_n);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack_n);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    logic bt;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(bt);
      b = {b[6:0], bt};
    end
    write_bit(~ack);
  endtask

  // Compare everything captured on rx against the expected queue.
  task automatic check_rx(input string tag);
    check({tag, " rx count"}, rx_got.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_got.size() > 0)
      check({tag, " rx byte"}, rx_got.pop_front(), exp_q.pop_front());
    exp_q.delete();
    rx_got.delete();
  endtask

  initial begin
    logic       ack_n;
    logic [7:0] b, d;
    int         n, k, m, s_stop, s_rd, s_busy, s_low;
    logic [7:0] model[$];

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_data", rx_data, 0);
    check("reset tx_rdreq", tx_rdreq, 0);
    check("reset busy", busy, 0);
    check("reset stop_det", stop_det, 0);
    check("reset sda released", sda_w, 1);
    check("reset state", dbg_state, ST_IDLE);
    rst = 1'b0;
    #(4 * Q);

    // Directed write: 0xA0, 0x12, 0x34, STOP.
    s_stop = stop_cnt;
    m_start();
    write_byte(8'hA0, ack_n); check("wr addr ack", ack_n, 0);
    check("wr busy", busy, 1);
    write_byte(8'h12, ack_n); check("wr d0 ack", ack_n, 0);
    write_byte(8'h34, ack_n); check("wr d1 ack", ack_n, 0);
    m_stop();
    #(4 * Q);
    exp_q.push_back({1'b1, 8'h12});
    exp_q.push_back({1'b0, 8'h34});
    check_rx("wr directed");
    check("wr stop_det once", stop_cnt - s_stop, 1);
    check("wr idle after stop", dbg_state, ST_IDLE);

    // Random writes to our address.
    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(1, 4);
      m_start();
      write_byte(8'hA0, ack_n); check("rw addr ack", ack_n, 0);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom_range(0, 255));
        write_byte(d, ack_n); check("rw data ack", ack_n, 0);
        exp_q.push_back({(i == 0), d});
      end
      m_stop();
      #(2 * Q);
      check_rx("rw random");
    end

    // Foreign addresses: 0xA2 plus random non-matching ones.
    for (int t = 0; t < 3; t++) begin
      b = (t == 0) ? 8'hA2 : 8'($urandom_range(0, 255));
      if (b[7:1] == 7'h50) b[7:1] = 7'h51;
      s_busy = busy_cnt; s_low = dut_low_cnt;
      m_start();
      write_byte(b, ack_n); check("foreign nack", ack_n, 1);
      write_byte(8'h55, ack_n); check("foreign data nack", ack_n, 1);
      check("foreign ignore", dbg_state, ST_IGNORE);
      m_stop();
      #(2 * Q);
      check("foreign busy", busy_cnt - s_busy, 0);
      check("foreign sda low", dut_low_cnt - s_low, 0);
      check_rx("foreign");
    end

    // Directed read: FIFO 0x9C, 0x3E; ACK first byte, NACK second.
    fifo_q.push_back(8'h9C); fifo_q.push_back(8'h3E);
    #(2 * Q);
    s_rd = rdreq_cnt;
    m_start();
    write_byte(8'hA1, ack_n); check("rd addr ack", ack_n, 0);
    read_byte(b, 1'b1); check("rd byte0", b, 8'h9C);
    read_byte(b, 1'b0); check("rd byte1", b, 8'h3E);
    check("rd ignore after nack", dbg_state, ST_IGNORE);
    #(2 * Q);
    check("rd still ignore", dbg_state, ST_IGNORE);
    m_stop();
    #(2 * Q);
    check("rd pops", rdreq_cnt - s_rd, 2);
    check("rd idle", dbg_state, ST_IDLE);

    // Read from an empty FIFO.
    s_rd = rdreq_cnt;
    m_start();
    write_byte(8'hA1, ack_n); check("empty addr ack", ack_n, 0);
    read_byte(b, 1'b0); check("empty byte", b, 8'hFF);
    m_stop();
    #(2 * Q);
    check("empty no pop", rdreq_cnt - s_rd, 0);

    // Random reads: k bytes queued, m bytes read, FF once exhausted.
    for (int t = 0; t < 3; t++) begin
      k = $urandom_range(0, 3);
      m = $urandom_range(1, 4);
      model.delete();
      for (int i = 0; i < k; i++) begin
        d = 8'($urandom_range(0, 255));
        fifo_q.push_back(d);
        model.push_back(d);
      end
      #(2 * Q);
      s_rd = rdreq_cnt;
      m_start();
      write_byte(8'hA1, ack_n); check("rr addr ack", ack_n, 0);
      for (int i = 0; i < m; i++) begin
        read_byte(b, (i != m - 1));
        check("rr byte", b, (i < k) ? model[i] : 8'hFF);
      end
      m_stop();
      #(2 * Q);
      check("rr pops", rdreq_cnt - s_rd, (k < m) ? k : m);
      fifo_q.delete();
    end

    // Write then repeated START into a read, one STOP at the end.
    fifo_q.push_back(8'hC5);
    #(2 * Q);
    s_stop = stop_cnt;
    m_start();
    write_byte(8'hA0, ack_n); check("rs addr ack", ack_n, 0);
    write_byte(8'h01, ack_n); check("rs data ack", ack_n, 0);
    m_start();
    write_byte(8'hA1, ack_n); check("rs read addr ack", ack_n, 0);
    read_byte(b, 1'b0); check("rs read byte", b, 8'hC5);
    check("rs no stop yet", stop_cnt - s_stop, 0);
    m_stop();
    #(2 * Q);
    check("rs stop once", stop_cnt - s_stop, 1);
    exp_q.push_back({1'b1, 8'h01});
    check_rx("rs");

    // Reset while the target is pulling SDA low for a 0 data bit.
    fifo_q.push_back(8'h00);
    #(2 * Q);
    m_start();
    write_byte(8'hA1, ack_n); check("rst addr ack", ack_n, 0);
    #Q;
    check("rst sda driven", sda_w, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst sda released", sda_w, 1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    s_rd = rdreq_cnt;
    fifo_q.push_back(8'h00);
    read_byte(b, 1'b1); check("rst after byte", b, 8'hFF);
    read_byte(b, 1'b1); check("rst after byte2", b, 8'hFF);
    check("rst state idle", dbg_state, ST_IDLE);
    check("rst no pop", rdreq_cnt - s_rd, 0);
    check_rx("rst no rx");
    m_stop();
    fifo_q.delete();
    #(2 * Q);
    m_start();
    write_byte(8'hA0, ack_n); check("post rst addr ack", ack_n, 0);
    write_byte(8'h7E, ack_n); check("post rst data ack", ack_n, 0);
    m_stop();
    #(2 * Q);
    exp_q.push_back({1'b1, 8'h7E});
    check_rx("post rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
